// File: rtl/matmul_mem_master_if.sv
// Control handshake and main-memory port of the matrix-multiply bus master.
interface matmul_mem_master_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        memread;
    logic        memwrite;
    logic [31:0] address;
    logic [31:0] data_out;
    logic [31:0] data_in;

    modport master (
        input  start, data_in,
        output busy, done, memread, memwrite, address, data_out
    );

    modport slave (
        output start, data_in,
        input  busy, done, memread, memwrite, address, data_out
    );
endinterface

// File: rtl/matmul_mem_master.sv
// Computes C = A x B (NxN signed 32-bit words) over a zero-wait memory port.
// Define MATMUL_SAT_EN for saturating accumulation; default wraps modulo 2^32.
module matmul_mem_master #(
    parameter int unsigned N      = 3,
    parameter logic [31:0] A_BASE = 32'h0000_0200,
    parameter logic [31:0] B_BASE = 32'h0000_0300,
    parameter logic [31:0] C_BASE = 32'h0000_0100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    matmul_mem_master_if.master  bus
);
    localparam int unsigned    CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [31:0]   acc_q, acc_d, a_q, a_d;
    logic [31:0]   acc_upd;
    logic [31:0]   idx_a, idx_b, idx_c;

    always_comb begin
        idx_a = 32'(N) * 32'(i_q) + 32'(k_q);
        idx_b = 32'(N) * 32'(k_q) + 32'(j_q);
        idx_c = 32'(N) * 32'(i_q) + 32'(j_q);
    end

`ifdef MATMUL_SAT_EN
    logic [63:0] prod;
    logic [31:0] prod_c;
    logic [32:0] sum;

    // Product clamped to 32 bits first, then the 33-bit sum clamped again.
    always_comb begin
        prod = {{32{a_q[31]}}, a_q} * {{32{bus.data_in[31]}}, bus.data_in};
        if (prod[63:31] == '0 || prod[63:31] == '1)
            prod_c = prod[31:0];
        else
            prod_c = prod[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        sum = {acc_q[31], acc_q} + {prod_c[31], prod_c};
        if (sum[32] != sum[31])
            acc_upd = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else
            acc_upd = sum[31:0];
    end
`else
    // Low word of the signed 64-bit product equals the unsigned low word.
    always_comb acc_upd = acc_q + a_q * bus.data_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        k_d          = k_q;
        acc_d        = acc_q;
        a_d          = a_q;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.address  = '0;
        bus.data_out = '0;
        unique case (state_q)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = RD_A;
                end
            end
            RD_A: begin
                bus.memread = 1'b1;
                bus.address = A_BASE + (idx_a << 2);
                a_d         = bus.data_in;
                state_d     = RD_B;
            end
            RD_B: begin
                bus.memread = 1'b1;
                bus.address = B_BASE + (idx_b << 2);
                acc_d       = acc_upd;
                if (k_q == LAST) begin
                    state_d = WR;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = RD_A;
                end
            end
            WR: begin
                bus.memwrite = 1'b1;
                bus.address  = C_BASE + (idx_c << 2);
                bus.data_out = acc_q;
                acc_d        = '0;
                k_d          = '0;
                if (j_q == LAST) begin
                    if (i_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        j_d     = '0;
                        i_d     = i_q + 1'b1;
                        state_d = RD_A;
                    end
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = RD_A;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_matmul_mem_master.sv
// Directed bench for matmul_mem_master (N=3) with a zero-wait memory model.
module tb_matmul_mem_master;
    typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;

    logic clk;
    logic rst_n;
    matmul_mem_master_if bus();

    matmul_mem_master #(.N(3), .A_BASE(32'h200), .B_BASE(32'h300), .C_BASE(32'h100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [256];
    assign bus.data_in = mem[bus.address[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    // Monitor: a write counts as landed only if reset is still high a cycle later.
    wr_t wlog[$];
    int  dlog[$];
    logic [31:0] alog[$];
    int  ovl = 0;
    logic pend_v = 1'b0;
    wr_t  pend;
    always @(negedge clk) begin
        if (pend_v && rst_n) wlog.push_back(pend);
        pend_v = rst_n && bus.memwrite;
        pend   = '{a: bus.address, d: bus.data_out};
        if (rst_n) begin
            if (bus.memread && bus.memwrite) ovl++;
            if (bus.done) dlog.push_back(ecount);
            if (bus.memread || bus.memwrite) alog.push_back(bus.address);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int sedge    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); #1;
        bus.start = 1'b1;
        sedge = ecount + 1;
        @(negedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk); #1;
            if (dlog.size() > target) begin
                ok = 1'b1;
                return;
            end
        end
        check_eq("done_timeout", 32'(dlog.size()), 32'(target + 1));
    endtask

    task automatic load(input logic [31:0] a [9], input logic [31:0] b [9]);
        for (int unsigned n = 0; n < 9; n++) begin
            mem[128 + n] = a[n];
            mem[192 + n] = b[n];
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"},     32'(bus.busy),     32'd0);
        check_eq({tag, "_done"},     32'(bus.done),     32'd0);
        check_eq({tag, "_memread"},  32'(bus.memread),  32'd0);
        check_eq({tag, "_memwrite"}, 32'(bus.memwrite), 32'd0);
        check_eq({tag, "_address"},  bus.address,       32'd0);
        check_eq({tag, "_data_out"}, bus.data_out,      32'd0);
    endtask

    task automatic check_writes(input string tag, input int wb, input logic [31:0] e [9]);
        for (int n = 0; n < 9; n++) begin
            if (wb + n < wlog.size()) begin
                check_eq($sformatf("%s_addr%0d", tag, n), wlog[wb + n].a, 32'h100 + 32'(4 * n));
                check_eq($sformatf("%s_c%0d", tag, n), wlog[wb + n].d, e[n]);
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [31:0] e [9], input bit chk_addr, input bit restart);
        int wb, db, ab;
        bit ok;
        logic [31:0] seq [7];
        seq = '{32'h200, 32'h300, 32'h204, 32'h30C, 32'h208, 32'h318, 32'h100};
        wb = wlog.size(); db = dlog.size(); ab = alog.size();
        pulse_start();
        if (restart) begin
            repeat (18) @(negedge clk);
            #1 bus.start = 1'b1;
            @(negedge clk); #1 bus.start = 1'b0;
        end
        wait_done(db, ok);
        if (ok) check_eq({tag, "_latency"}, 32'(dlog[db] - sedge), 32'd63);
        @(negedge clk); #1;
        check_eq({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_nwrites"}, 32'(wlog.size() - wb), 32'd9);
        check_writes(tag, wb, e);
        if (chk_addr)
            for (int n = 0; n < 7; n++)
                if (ab + n < alog.size())
                    check_eq($sformatf("%s_seq%0d", tag, n), alog[ab + n], seq[n]);
        if (restart) begin
            repeat (70) @(negedge clk);
            #1 check_eq({tag, "_done_count"}, 32'(dlog.size() - db), 32'd1);
        end
    endtask

    logic [31:0] a_seq [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    logic [31:0] b_id  [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    logic [31:0] b_rev [9] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    logic [31:0] c_gen [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    logic [31:0] a_ov  [9] = '{32'h10000, 32'h10000, 32'h10000, 0, 0, 0, 0, 0, 0};
    logic [31:0] b_ov  [9] = '{32'h10000, 0, 0, 32'h10000, 0, 0, 32'h10000, 0, 0};
    logic [31:0] c_ov  [9];

    initial begin
        int wb, db;
        bit ok;
        for (int unsigned n = 0; n < 256; n++) mem[n] = '0;
        bus.start = 1'b0;
        rst_n = 1'b0;
`ifdef MATMUL_SAT_EN
        c_ov = '{32'h7FFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0};
`else
        c_ov = '{32'h0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        load(a_seq, b_id);
        run_check("ident", a_seq, 1'b0, 1'b0);

        load(a_seq, b_rev);
        run_check("general", c_gen, 1'b1, 1'b0);

        load(a_ov, b_ov);
        run_check("overflow", c_ov, 1'b0, 1'b0);

        load(a_seq, b_rev);
        run_check("restart_ignored", c_gen, 1'b0, 1'b1);

        // Abort during the write of C[1][0].
        wb = wlog.size();
        pulse_start();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            if (bus.memwrite && bus.address == 32'h10C) break;
        end
        check_eq("abort_reached_wr", bus.address, 32'h10C);
        rst_n = 1'b0;
        #1 check_outputs_zero("abort");
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        check_eq("abort_nwrites", 32'(wlog.size() - wb), 32'd3);
        for (int n = 0; n < 3; n++)
            if (wb + n < wlog.size())
                check_eq($sformatf("abort_addr%0d", n), wlog[wb + n].a, 32'h100 + 32'(4 * n));
        run_check("after_abort", c_gen, 1'b0, 1'b0);

        // Start held high: two back-to-back runs.
        db = dlog.size();
        wb = wlog.size();
        @(negedge clk); #1;
        bus.start = 1'b1;
        sedge = ecount + 1;
        wait_done(db + 1, ok);
        bus.start = 1'b0;
        if (ok) begin
            check_eq("b2b_latency", 32'(dlog[db] - sedge), 32'd63);
            check_eq("b2b_spacing", 32'(dlog[db + 1] - dlog[db]), 32'd65);
        end
        repeat (3) @(negedge clk);
        #1 check_eq("b2b_nwrites", 32'(wlog.size() - wb), 32'd18);
        check_writes("b2b_run2", wb + 9, c_gen);
        check_eq("b2b_idle", 32'(bus.busy), 32'd0);

        check_eq("no_overlap", 32'(ovl), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
